pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 157 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock with
// bounded retries, supervises the lock while running and latches a fault.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 64,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LOCK,
    input  logic       CLEAR_FAULT,
    output logic       PLL_RESETB,
    output logic       READY,
    output logic       FAULT,
    output logic [1:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);

    localparam logic [2:0] ST_HOLD      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    localparam logic [15:0] C_HOLD_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] C_STABLE_LAST  = 16'(LOCK_STABLE - 1);
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]  C_MAX_RETRIES  = 2'(MAX_RETRIES);

    logic        r_lock_meta;
    logic        r_lock_s;
    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_pll_resetb;
    logic        r_ready;
    logic        r_fault;
    logic [1:0]  r_retry_cnt;
    logic [7:0]  r_loss_cnt;

    logic [2:0]  w_next_state;
    logic [1:0]  w_next_retry;
    logic        w_loss_inc;
    logic        w_state_change;
    logic        w_cnt_run;

    // LOCK comes from the PLL's own domain; only r_lock_s is used below.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= LOCK;
            r_lock_s    <= r_lock_meta;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry_cnt;
        w_loss_inc   = 1'b0;
        case (r_state)
            ST_HOLD: begin
                if (r_cnt == C_HOLD_LAST) begin
                    w_next_state = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the timeout cycle takes priority over the retry.
                if (r_lock_s) begin
                    w_next_state = ST_STABLE;
                end else if (r_cnt == C_TIMEOUT_LAST) begin
                    if (r_retry_cnt < C_MAX_RETRIES) begin
                        w_next_state = ST_HOLD;
                        w_next_retry = r_retry_cnt + 2'd1;
                    end else begin
                        w_next_state = ST_FAULT;
                    end
                end
            end
            ST_STABLE: begin
                if (!r_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_next_state = ST_RUN;
                    w_next_retry = 2'd0;
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_next_state = ST_HOLD;
                    w_loss_inc   = (r_loss_cnt != 8'hFF);
                end
            end
            ST_FAULT: begin
                if (CLEAR_FAULT) begin
                    w_next_state = ST_HOLD;
                    w_next_retry = 2'd0;
                end
            end
            default: begin
                w_next_state = ST_HOLD;
            end
        endcase
    end

    assign w_state_change = (w_next_state != r_state);
    assign w_cnt_run      = (r_state == ST_HOLD) || (r_state == ST_WAIT_LOCK) ||
                            (r_state == ST_STABLE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_HOLD;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (w_state_change) begin
                r_cnt <= 16'd0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Outputs are decoded from the next state, so they are plain flops that
    // switch on the same edge as r_state and never glitch.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pll_resetb <= 1'b0;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
            r_retry_cnt  <= 2'd0;
            r_loss_cnt   <= 8'd0;
        end else begin
            r_pll_resetb <= (w_next_state == ST_WAIT_LOCK) ||
                            (w_next_state == ST_STABLE) ||
                            (w_next_state == ST_RUN);
            r_ready      <= (w_next_state == ST_RUN);
            r_fault      <= (w_next_state == ST_FAULT);
            r_retry_cnt  <= w_next_retry;
            if (w_loss_inc) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
        end
    end

    assign PLL_RESETB = r_pll_resetb;
    assign READY      = r_ready;
    assign FAULT      = r_fault;
    assign RETRY_CNT  = r_retry_cnt;
    assign LOSS_CNT   = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed vector table, multi-cycle corner
// sequences and a randomized run against a phase/countdown reference model.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES   = 16;
    localparam int LOCK_STABLE  = 64;
    localparam int LOCK_TIMEOUT = 4096;
    localparam int MAX_RETRIES  = 3;
    localparam int ATTEMPT      = RST_CYCLES + LOCK_TIMEOUT;
    // Reset release (or lock return after a HOLD entry) to READY, LOCK held high.
    localparam int BRINGUP      = RST_CYCLES + 1 + LOCK_STABLE;
    // LOCK returning high during STABLE/WAIT_LOCK: 2 sync flops, 1 WAIT cycle, window.
    localparam int RELOCK       = 2 + 1 + LOCK_STABLE;

    localparam int SEL_READY = 0;
    localparam int SEL_FAULT = 1;
    localparam int SEL_RETRY = 2;
    localparam int SEL_LOSS  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       clear_fault = 1'b0;
    logic       pll_resetb;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n;
    int cyc;
    int sel;
    int seg_len;

    pll_lock_sequencer #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .MAX_RETRIES (MAX_RETRIES)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .LOCK       (lock),
        .CLEAR_FAULT(clear_fault),
        .PLL_RESETB (pll_resetb),
        .READY      (ready),
        .FAULT      (fault),
        .RETRY_CNT  (retry_cnt),
        .LOSS_CNT   (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_HOLD, M_WAIT, M_STABLE, M_RUN, M_FAULT} phase_t;
    phase_t     m_phase = M_HOLD;
    int         m_left  = RST_CYCLES;   // cycles still to go in a timed phase
    logic [1:0] m_sync  = 2'b00;        // m_sync[1] is the synchronized lock
    logic       m_ls;
    int         m_retry = 0;
    int         m_loss  = 0;
    int         m_exp;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = M_HOLD;
                m_left  = RST_CYCLES;
                m_sync  = 2'b00;
                m_retry = 0;
                m_loss  = 0;
            end else begin
                m_ls   = m_sync[1];
                m_sync = {m_sync[0], lock};
                case (m_phase)
                    M_HOLD: begin
                        m_left--;
                        if (m_left == 0) begin m_phase = M_WAIT; m_left = LOCK_TIMEOUT; end
                    end
                    M_WAIT: begin
                        if (m_ls) begin
                            m_phase = M_STABLE; m_left = LOCK_STABLE;
                        end else begin
                            m_left--;
                            if (m_left == 0) begin
                                if (m_retry < MAX_RETRIES) begin
                                    m_retry++; m_phase = M_HOLD; m_left = RST_CYCLES;
                                end else begin
                                    m_phase = M_FAULT;
                                end
                            end
                        end
                    end
                    M_STABLE: begin
                        if (!m_ls) begin
                            m_phase = M_WAIT; m_left = LOCK_TIMEOUT;
                        end else begin
                            m_left--;
                            if (m_left == 0) begin m_phase = M_RUN; m_retry = 0; end
                        end
                    end
                    M_RUN: begin
                        if (!m_ls) begin
                            m_phase = M_HOLD; m_left = RST_CYCLES;
                            if (m_loss < 255) m_loss++;
                        end
                    end
                    default: begin
                        if (clear_fault) begin m_phase = M_HOLD; m_left = RST_CYCLES; m_retry = 0; end
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_exp = ((m_phase == M_WAIT || m_phase == M_STABLE || m_phase == M_RUN) ? 1 << 12 : 0)
                      | ((m_phase == M_RUN)   ? 1 << 11 : 0)
                      | ((m_phase == M_FAULT) ? 1 << 10 : 0)
                      | (m_retry << 8) | m_loss;
                check("model_cycle", 32'({pll_resetb, ready, fault, retry_cnt, loss_cnt}), m_exp);
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] cur(input int s);
        case (s)
            SEL_READY: return 32'(ready);
            SEL_FAULT: return 32'(fault);
            SEL_RETRY: return 32'(retry_cnt);
            default:   return 32'(loss_cnt);
        endcase
    endfunction

    task automatic wait_for(input int s, input int val, input int bound, output int cnt);
        cnt = 0;
        while (cur(s) !== val && cnt < bound) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic do_reset(input logic lock_val);
        @(negedge clk);
        rst = 1'b1;
        lock = lock_val;
        clear_fault = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all(input string name, input logic rb, input logic rd, input logic ft,
                             input logic [1:0] rt, input logic [7:0] ls);
        check({name, "_resetb"}, 32'(pll_resetb), 32'(rb));
        check({name, "_ready"},  32'(ready),      32'(rd));
        check({name, "_fault"},  32'(fault),      32'(ft));
        check({name, "_retry"},  32'(retry_cnt),  32'(rt));
        check({name, "_loss"},   32'(loss_cnt),   32'(ls));
    endtask

    task automatic async_reset_check(input string name);
        #2 rst = 1'b1;
        #1 check_all({name, "_async_rst"}, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // rise_edge: edge index after reset release whose following negedge raises LOCK.
    task automatic timeout_race(input string name, input int rise_edge,
                                input logic exp_rb, input logic [1:0] exp_rt);
        do_reset(1'b0);
        repeat (rise_edge) @(posedge clk);
        @(negedge clk);
        lock = 1'b1;
        repeat (ATTEMPT - rise_edge) @(posedge clk);
        @(negedge clk);
        check({name, "_resetb"}, 32'(pll_resetb), 32'(exp_rb));
        check({name, "_retry"},  32'(retry_cnt),  32'(exp_rt));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string      name;
        int         cycles;
        logic       lock;
        logic       clear;
        logic       rb;
        logic       rd;
        logic       ft;
        logic [1:0] rt;
        logic [7:0] ls;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input int cycles, input logic lk, input logic clr,
                           input logic rb, input logic rd, input logic ft,
                           input logic [1:0] rt, input logic [7:0] ls);
        vec_t v;
        v.name = name; v.cycles = cycles; v.lock = lk; v.clear = clr;
        v.rb = rb; v.rd = rd; v.ft = ft; v.rt = rt; v.ls = ls;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Nominal bring-up with LOCK tied high, then one loss in RUN and re-lock.
        add_vec("hold_first",    1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        add_vec("hold_last",     14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        add_vec("wait_entry",    1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        add_vec("stable_entry",  1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        add_vec("stable_last",   63, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        add_vec("run_entry",     1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        add_vec("clear_in_run",  5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        add_vec("drop_sync1",    1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        add_vec("drop_sync2",    1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        add_vec("loss_hold",     1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);
        add_vec("rehold_last",   15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);
        add_vec("rewait",        1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
        add_vec("restable_last", 64, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1);
        add_vec("rerun",         1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1);

        #12 check_all("reset_state", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

        do_reset(1'b1);
        foreach (vecs[i]) begin
            lock = vecs[i].lock;
            clear_fault = vecs[i].clear;
            repeat (vecs[i].cycles) @(posedge clk);
            @(negedge clk);
            check_all(vecs[i].name, vecs[i].rb, vecs[i].rd, vecs[i].ft, vecs[i].rt, vecs[i].ls);
        end
        clear_fault = 1'b0;

        // Lock chatter: LOCK low for 3 cycles at STABLE count 40.
        do_reset(1'b1);
        repeat (RST_CYCLES + 1 + 40) @(posedge clk);
        @(negedge clk);
        check("chatter_pre_ready", 32'(ready), 0);
        lock = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        lock = 1'b1;
        check("chatter_resetb", 32'(pll_resetb), 1);
        wait_for(SEL_READY, 1, 200, n);
        check("chatter_relock_latency", n, RELOCK);
        check("chatter_retry", 32'(retry_cnt), 0);

        // Timeout to fault, LOCK ignored in FAULT, then CLEAR_FAULT.
        do_reset(1'b0);
        for (int r = 1; r <= MAX_RETRIES; r++) begin
            wait_for(SEL_RETRY, r, ATTEMPT + 10, n);
            check($sformatf("timeout%0d_latency", r), n, ATTEMPT);
        end
        wait_for(SEL_FAULT, 1, ATTEMPT + 10, n);
        check("fault_latency", n, ATTEMPT);
        check_all("fault_entry", 1'b0, 1'b0, 1'b1, 2'd3, 8'd0);
        lock = 1'b1;
        repeat (20) @(negedge clk);
        check_all("fault_lock_ignored", 1'b0, 1'b0, 1'b1, 2'd3, 8'd0);
        lock = 1'b0;
        repeat (5) @(negedge clk);
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        check_all("fault_cleared", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        repeat (RST_CYCLES - 1) @(negedge clk);
        check("post_clear_hold_last", 32'(pll_resetb), 0);
        @(negedge clk);
        check("post_clear_wait", 32'(pll_resetb), 1);

        // lock_s first high on the timeout cycle wins; one cycle later loses.
        timeout_race("race_lock_wins", ATTEMPT - 3, 1'b1, 2'd0);
        wait_for(SEL_READY, 1, 200, n);
        check("race_ready_latency", n, LOCK_STABLE);
        timeout_race("race_lock_late", ATTEMPT - 2, 1'b0, 2'd1);

        // Repeated loss in RUN with saturation of LOSS_CNT.
        do_reset(1'b1);
        for (int i = 1; i <= 300; i++) begin
            wait_for(SEL_READY, 1, 200, n);
            check("loss_relock_latency", n, BRINGUP);
            lock = 1'b0;
            @(negedge clk);
            lock = 1'b1;
            wait_for(SEL_READY, 0, 10, n);
            check("loss_ready_drop", n, 2);
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
                check($sformatf("loss_cnt_after_%0d", i), 32'(loss_cnt), (i > 255) ? 255 : i);
        end

        // Asynchronous reset during STABLE and during RUN.
        do_reset(1'b1);
        repeat (40) @(negedge clk);
        check("stable_pre_reset_resetb", 32'(pll_resetb), 1);
        async_reset_check("stable");
        wait_for(SEL_READY, 1, 200, n);
        check("stable_reset_rebringup", n, BRINGUP);
        lock = 1'b0;
        @(negedge clk);
        lock = 1'b1;
        wait_for(SEL_READY, 0, 10, n);
        wait_for(SEL_READY, 1, 200, n);
        check("run_pre_reset_loss", 32'(loss_cnt), 1);
        async_reset_check("run");
        wait_for(SEL_READY, 1, 200, n);
        check("run_reset_rebringup", n, BRINGUP);

        // Randomized LOCK segments and stray CLEAR_FAULT pulses, model-checked.
        do_reset(1'b1);
        cyc = 0;
        while (cyc < 8000) begin
            sel = $urandom_range(0, 99);
            if (sel < 55) begin
                lock = 1'b1; seg_len = $urandom_range(1, 150);
            end else if (sel < 95) begin
                lock = 1'b0; seg_len = $urandom_range(1, 6);
            end else begin
                lock = 1'b0; seg_len = $urandom_range(LOCK_TIMEOUT - 100, LOCK_TIMEOUT + 100);
            end
            for (int k = 0; k < seg_len; k++) begin
                clear_fault = ($urandom_range(0, 39) == 0);
                @(negedge clk);
                cyc++;
            end
        end
        clear_fault = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
